// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : run_ctrl_pkg
// Purpose  : Shared state encoding and default widths for run_controller.
// Revision : 1.0
// ============================================================================
package run_ctrl_pkg;

   localparam int c_PC_WIDTH    = 7;
   localparam int c_DIV_WIDTH   = 24;
   localparam int c_COUNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP  = 2'd1,
      RUN   = 2'd2,
      BREAK = 2'd3
   } run_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Purpose  : Run-rate down-counter; clear, reload from divisor, or decrement.
// Revision : 1.0
// ============================================================================
module tick_divider
   import run_ctrl_pkg::*;
#(
   parameter int DIV_WIDTH = c_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clear,
   input  logic                 i_load,
   input  logic                 i_dec,
   input  logic [DIV_WIDTH-1:0] i_divisor,
   output logic                 o_zero
);

   logic [DIV_WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_divisor;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - DIV_WIDTH'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module   : run_controller
// Purpose  : Turns step/run/halt commands and a PC breakpoint into a
//            one-cycle processor clock enable (ProcStep).
// Revision : 1.0
// ============================================================================
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int PC_WIDTH    = c_PC_WIDTH,
   parameter int DIV_WIDTH   = c_DIV_WIDTH,
   parameter int COUNT_WIDTH = c_COUNT_WIDTH
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   StepStrobe,
   input  logic                   RunCmd,
   input  logic                   HaltCmd,
   input  logic [DIV_WIDTH-1:0]   Divisor,
   input  logic                   BreakEn,
   input  logic [PC_WIDTH-1:0]    BreakAddr,
   input  logic [PC_WIDTH-1:0]    PC,
   output logic                   ProcStep,
   output logic                   Running,
   output logic                   BreakHit,
   output logic [COUNT_WIDTH-1:0] StepCount
);

   run_state_t             r_state;
   run_state_t             w_next_state;
   logic                   r_skip;
   logic                   w_next_skip;
   logic                   w_pulse;
   logic                   w_div_clear;
   logic                   w_div_load;
   logic                   w_div_dec;
   logic                   w_div_zero;
   logic                   w_break_match;
   logic [COUNT_WIDTH-1:0] r_step_count;

   tick_divider #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_divider (
      .clk       (Clock),
      .rst_n     (Reset),
      .i_clear   (w_div_clear),
      .i_load    (w_div_load),
      .i_dec     (w_div_dec),
      .i_divisor (Divisor),
      .o_zero    (w_div_zero)
   );

   assign w_break_match = BreakEn && (PC == BreakAddr);

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_skip  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_skip  <= w_next_skip;
      end
   end

   // Skip lets the first pulse after entering RUN execute past a breakpoint.
   always_comb begin
      w_next_state = r_state;
      w_next_skip  = r_skip;
      w_pulse      = 1'b0;
      w_div_clear  = 1'b0;
      w_div_load   = 1'b0;
      w_div_dec    = 1'b0;
      case (r_state)
         IDLE: begin
            if (RunCmd) begin
               w_next_state = RUN;
               w_next_skip  = 1'b1;
               w_div_clear  = 1'b1;
            end else if (StepStrobe) begin
               w_next_state = STEP;
            end
         end
         STEP: begin
            w_pulse      = 1'b1;
            w_next_state = IDLE;
         end
         RUN: begin
            if (HaltCmd) begin
               w_next_state = IDLE;
            end else if (w_div_zero) begin
               if (w_break_match && !r_skip) begin
                  w_next_state = BREAK;
               end else begin
                  w_pulse     = 1'b1;
                  w_next_skip = 1'b0;
                  w_div_load  = 1'b1;
               end
            end else begin
               w_div_dec = 1'b1;
            end
         end
         BREAK: begin
            if (HaltCmd) begin
               w_next_state = IDLE;
            end else if (RunCmd) begin
               w_next_state = RUN;
               w_next_skip  = 1'b1;
               w_div_clear  = 1'b1;
            end else if (StepStrobe) begin
               w_next_state = STEP;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_step_count <= '0;
      end else if (ProcStep) begin
         r_step_count <= r_step_count + COUNT_WIDTH'(1);
      end
   end

   // A cycle with reset asserted never enables the processor.
   assign ProcStep  = w_pulse && Reset;
   assign Running   = (r_state == RUN);
   assign BreakHit  = (r_state == BREAK);
   assign StepCount = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_controller
// Purpose  : Directed, self-checking bench for run_controller.
// Revision : 1.0
// ============================================================================
module tb_run_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        step = 1'b0;
   logic        run = 1'b0;
   logic        halt = 1'b0;
   logic [23:0] divisor = '0;
   logic        brk_en = 1'b0;
   logic [6:0]  brk_addr = '0;
   logic [6:0]  pc = '0;
   logic        proc_step;
   logic        running;
   logic        break_hit;
   logic [15:0] step_count;

   int passed = 0;
   int total  = 0;
   int pulses = 0;
   int p0;

   typedef struct {
      logic        step;
      logic        run;
      logic        halt;
      logic        ps;
      logic        running;
      logic        brk;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl [11];

   run_controller dut (
      .Clock      (clk),
      .Reset      (rst_n),
      .StepStrobe (step),
      .RunCmd     (run),
      .HaltCmd    (halt),
      .Divisor    (divisor),
      .BreakEn    (brk_en),
      .BreakAddr  (brk_addr),
      .PC         (pc),
      .ProcStep   (proc_step),
      .Running    (running),
      .BreakHit   (break_hit),
      .StepCount  (step_count)
   );

   always #5 clk = ~clk;

   // Processor stand-in: PC advances once per enabled clock.
   always @(posedge clk) begin
      if (!rst_n) pc <= '0;
      else if (proc_step) pc <= pc + 7'd1;
   end

   always @(posedge clk) begin
      if (proc_step) pulses <= pulses + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Advance to the next cycle and apply inputs for it; outputs settled on return.
   task automatic cyc(input logic s, input logic r, input logic h);
      @(posedge clk);
      #1;
      step = s;
      run  = r;
      halt = h;
      #1;
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      step = 1'b0; run = 1'b0; halt = 1'b0;
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};

      // Reset state
      do_reset(3);
      check("rst_procstep", proc_step, 1'b0);
      check("rst_running", running, 1'b0);
      check("rst_breakhit", break_hit, 1'b0);
      check("rst_count", step_count, 16'd0);

      // Vector table: single step, run+step collision, Divisor=1 run, halt
      divisor = 24'd1;
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].step, tbl[i].run, tbl[i].halt);
         check($sformatf("tbl%0d_procstep", i), proc_step, tbl[i].ps);
         check($sformatf("tbl%0d_running", i), running, tbl[i].running);
         check($sformatf("tbl%0d_breakhit", i), break_hit, tbl[i].brk);
         check($sformatf("tbl%0d_count", i), step_count, tbl[i].cnt);
      end

      // Divisor=3: pulses at 1,5,9 but halt in cycle 9 suppresses that one
      divisor = 24'd3;
      cyc(1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         cyc(1'b0, 1'b0, (c == 9));
         check($sformatf("div3_c%0d_procstep", c), proc_step, (c == 1 || c == 5));
      end
      cyc(1'b0, 1'b0, 1'b0);
      check("div3_halt_running", running, 1'b0);
      check("div3_halt_procstep", proc_step, 1'b0);

      // Reset asserted mid-run
      divisor = 24'd0;
      cyc(1'b0, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      check("midrun_pulsing", proc_step, 1'b1);
      @(posedge clk); #1; rst_n = 1'b0; #1;
      check("midrun_rst_gate", proc_step, 1'b0);
      repeat (2) begin
         @(posedge clk); #2;
         check("midrun_rst_procstep", proc_step, 1'b0);
         check("midrun_rst_count", step_count, 16'd0);
         check("midrun_rst_running", running, 1'b0);
      end
      @(posedge clk); #1; rst_n = 1'b1; #1;
      p0 = pulses;
      repeat (5) cyc(1'b0, 1'b0, 1'b0);
      check("midrun_no_pulse_after", pulses - p0, 0);
      check("midrun_idle", running, 1'b0);

      // Breakpoint at PC 5 with Divisor=0, then resume past it
      do_reset(1);
      brk_en = 1'b1;
      brk_addr = 7'h05;
      p0 = pulses;
      cyc(1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         cyc(1'b0, 1'b0, 1'b0);
         check($sformatf("brk_c%0d_procstep", c), proc_step, (c <= 5));
      end
      cyc(1'b0, 1'b0, 1'b0);
      check("brk_hit", break_hit, 1'b1);
      check("brk_running", running, 1'b0);
      check("brk_pc", pc, 7'h05);
      check("brk_pulses", pulses - p0, 5);
      cyc(1'b0, 1'b1, 1'b0);
      check("brk_no_pulse", proc_step, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("resume_pulse", proc_step, 1'b1);
      check("resume_running", running, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      check("resume_halt_procstep", proc_step, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("resume_pc", pc, 7'h06);
      check("resume_idle", running, 1'b0);

      // In BREAK, halt and run together: halt wins
      do_reset(1);
      cyc(1'b0, 1'b1, 1'b0);
      repeat (7) cyc(1'b0, 1'b0, 1'b0);
      check("brk2_hit", break_hit, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      check("brk2_halt_running", running, 1'b0);
      check("brk2_halt_breakhit", break_hit, 1'b0);
      check("brk2_halt_procstep", proc_step, 1'b0);

      // StepCount wrap: 65534 run pulses, then two single steps
      do_reset(1);
      brk_en = 1'b0;
      p0 = pulses;
      cyc(1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 65534; c++) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      check("wrap_halt_procstep", proc_step, 1'b0);
      check("wrap_pulses", pulses - p0, 65534);
      cyc(1'b1, 1'b0, 1'b0);
      check("wrap_count_fffe", step_count, 16'hFFFE);
      cyc(1'b0, 1'b0, 1'b0);
      check("wrap_step1", proc_step, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      check("wrap_count_ffff", step_count, 16'hFFFF);
      cyc(1'b0, 1'b0, 1'b0);
      check("wrap_step2", proc_step, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      check("wrap_count_0000", step_count, 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
